// File: rtl/clock_reg_arbiter_pkg.sv
// Shared field layout, limits and FSM encoding for the clock register arbiter.
// Time is {meridian, hour, min, sec}; date is {year, month, day}.
package clock_reg_arbiter_pkg;

    localparam int SEC_LSB      = 0;
    localparam int SEC_MSB      = 5;
    localparam int MIN_LSB      = 6;
    localparam int MIN_MSB      = 11;
    localparam int HOUR_LSB     = 12;
    localparam int HOUR_MSB     = 16;
    localparam int MERIDIAN_BIT = 17;

    localparam int DAY_LSB      = 0;
    localparam int DAY_MSB      = 4;
    localparam int MONTH_LSB    = 5;
    localparam int MONTH_MSB    = 8;
    localparam int YEAR_LSB     = 9;
    localparam int YEAR_MSB     = 15;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [3:0] MONTH_MAX = 4'd12;

    localparam logic [6:0]  YEAR_MAX_DEFAULT   = 7'd99;
    localparam logic [15:0] DEFAULT_RESET_DATE = 16'h0021;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_ACK,
        ST_WAIT_DROP
    } state_t;

endpackage

// File: rtl/clock_reg_arbiter_month_len.sv
// Days in a given month; February is a leap month whenever year%4 == 0.
module month_len (
    input  logic [6:0] year,
    input  logic [3:0] month,
    output logic [4:0] days
);

    always_comb begin
        days = 5'd31;
        case (month)
            4'd2:                days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            default:             days = 5'd31;
        endcase
    end

endmodule

// File: rtl/clock_reg_arbiter.sv
// Owns the running time/date/alarm registers and arbitrates between the 1 Hz
// count step and settings commits from the key controller.
module clock_reg_arbiter
    import clock_reg_arbiter_pkg::*;
#(
    parameter logic [6:0]  YEAR_MAX   = YEAR_MAX_DEFAULT,
    parameter logic [15:0] RESET_DATE = DEFAULT_RESET_DATE
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        TICK,
    input  logic [5:0]  MODE,
    input  logic        SETTING,
    input  logic        ALARM_ENABLE,
    input  logic [17:0] NEW_TIME,
    input  logic [15:0] NEW_DATE,
    input  logic [16:0] NEW_ALARM,
    output logic        SETTING_OK,
    output logic [17:0] CUR_TIME,
    output logic [15:0] CUR_DATE,
    output logic [16:0] CUR_ALARM,
    output logic        ALARM_HIT,
    output logic        BUSY
);

    state_t state, state_next;

    logic [5:0] cur_sec, cur_min, sec_n, min_n;
    logic [4:0] cur_hour, cur_day, hour_n, day_n, cur_days;
    logic [3:0] cur_month, month_n;
    logic [6:0] cur_year, year_n;

    logic [6:0] new_year, san_year;
    logic [3:0] new_month, san_month;
    logic [4:0] new_day, san_day, new_days;

    logic do_step, do_commit;
    logic unused_mode;

    assign unused_mode = ^MODE[4:1];

    assign cur_sec   = CUR_TIME[SEC_MSB:SEC_LSB];
    assign cur_min   = CUR_TIME[MIN_MSB:MIN_LSB];
    assign cur_hour  = CUR_TIME[HOUR_MSB:HOUR_LSB];
    assign cur_day   = CUR_DATE[DAY_MSB:DAY_LSB];
    assign cur_month = CUR_DATE[MONTH_MSB:MONTH_LSB];
    assign cur_year  = CUR_DATE[YEAR_MSB:YEAR_LSB];

    assign new_day   = NEW_DATE[DAY_MSB:DAY_LSB];
    assign new_month = NEW_DATE[MONTH_MSB:MONTH_LSB];
    assign new_year  = NEW_DATE[YEAR_MSB:YEAR_LSB];

    month_len u_cur_len (
        .year  (cur_year),
        .month (cur_month),
        .days  (cur_days)
    );

    // Year is clamped before the month length lookup so the stored date is valid
    assign san_month = (new_month == 4'd0 || new_month > MONTH_MAX) ? 4'd1 : new_month;
    assign san_year  = (new_year > YEAR_MAX) ? YEAR_MAX : new_year;

    month_len u_new_len (
        .year  (san_year),
        .month (san_month),
        .days  (new_days)
    );

    assign san_day = (new_day == 5'd0)    ? 5'd1 :
                     (new_day > new_days) ? new_days : new_day;

    always_comb begin
        sec_n   = cur_sec;
        min_n   = cur_min;
        hour_n  = cur_hour;
        day_n   = cur_day;
        month_n = cur_month;
        year_n  = cur_year;
        if (cur_sec >= SEC_MAX) begin
            sec_n = 6'd0;
            if (cur_min >= MIN_MAX) begin
                min_n = 6'd0;
                if (cur_hour >= HOUR_MAX) begin
                    hour_n = 5'd0;
                    if (cur_day >= cur_days) begin
                        day_n = 5'd1;
                        if (cur_month >= MONTH_MAX) begin
                            month_n = 4'd1;
                            year_n  = (cur_year >= YEAR_MAX) ? 7'd0 : cur_year + 7'd1;
                        end else begin
                            month_n = cur_month + 4'd1;
                        end
                    end else begin
                        day_n = cur_day + 5'd1;
                    end
                end else begin
                    hour_n = cur_hour + 5'd1;
                end
            end else begin
                min_n = cur_min + 6'd1;
            end
        end else begin
            sec_n = cur_sec + 6'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (SETTING) state_next = ST_COMMIT;
            ST_COMMIT:    state_next = ST_ACK;
            ST_ACK:       state_next = ST_WAIT_DROP;
            ST_WAIT_DROP: if (!SETTING) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // A tick is only honoured in an idle cycle with no commit request pending
    assign do_step    = (state == ST_IDLE) && !SETTING && TICK && !MODE[0];
    assign do_commit  = (state == ST_COMMIT);
    assign SETTING_OK = (state == ST_ACK);
    assign BUSY       = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            CUR_TIME  <= 18'd0;
            CUR_DATE  <= RESET_DATE;
            CUR_ALARM <= 17'd0;
            ALARM_HIT <= 1'b0;
        end else begin
            ALARM_HIT <= 1'b0;
            if (do_commit) begin
                if (!MODE[5]) begin
                    CUR_TIME <= NEW_TIME;
                    CUR_DATE <= {san_year, san_month, san_day};
                end else begin
                    CUR_ALARM <= NEW_ALARM;
                end
            end else if (do_step) begin
                CUR_TIME  <= {CUR_TIME[MERIDIAN_BIT], hour_n, min_n, sec_n};
                CUR_DATE  <= {year_n, month_n, day_n};
                ALARM_HIT <= ALARM_ENABLE && ({hour_n, min_n, sec_n} == CUR_ALARM);
            end
        end
    end

endmodule

// File: tb/tb_clock_reg_arbiter.sv
// Scoreboard bench for clock_reg_arbiter: a calendar-level model predicts
// commit acknowledges and alarm pulses, a monitor pops them as the DUT shows them.
module tb_clock_reg_arbiter;

    logic        CLK = 1'b0;
    logic        RESETN, TICK, SETTING, ALARM_ENABLE;
    logic [5:0]  MODE;
    logic [17:0] NEW_TIME;
    logic [15:0] NEW_DATE;
    logic [16:0] NEW_ALARM;
    logic        SETTING_OK, ALARM_HIT, BUSY;
    logic [17:0] CUR_TIME;
    logic [15:0] CUR_DATE;
    logic [16:0] CUR_ALARM;

    clock_reg_arbiter dut (
        .CLK(CLK), .RESETN(RESETN), .TICK(TICK), .MODE(MODE), .SETTING(SETTING),
        .ALARM_ENABLE(ALARM_ENABLE), .NEW_TIME(NEW_TIME), .NEW_DATE(NEW_DATE),
        .NEW_ALARM(NEW_ALARM), .SETTING_OK(SETTING_OK), .CUR_TIME(CUR_TIME),
        .CUR_DATE(CUR_DATE), .CUR_ALARM(CUR_ALARM), .ALARM_HIT(ALARM_HIT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int mer, hr, mn, sc, yr, mo, dy, ahr, amn, asc;
    } model_t;

    typedef struct {
        logic [17:0] t;
        logic [15:0] d;
        logic [16:0] a;
    } ack_exp_t;

    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    int       mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    model_t   m;
    ack_exp_t ack_q[$];
    int       hit_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int days_in(int y, int mo);
        if (mo == 2 && (y % 4) == 0) return 29;
        return mdays[mo-1];
    endfunction

    function automatic logic [17:0] mk_time(int mer, int h, int mi, int s);
        int v;
        v = mer * 131072 + h * 4096 + mi * 64 + s;
        return v[17:0];
    endfunction

    function automatic logic [16:0] mk_alarm(int h, int mi, int s);
        int v;
        v = h * 4096 + mi * 64 + s;
        return v[16:0];
    endfunction

    function automatic logic [15:0] mk_date(int y, int mo, int d);
        int v;
        v = y * 512 + mo * 32 + d;
        return v[15:0];
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s = '{mer:0, hr:0, mn:0, sc:0, yr:0, mo:1, dy:1, ahr:0, amn:0, asc:0};
        return s;
    endfunction

    function automatic model_t step(model_t s);
        s.sc++;
        if (s.sc == 60) begin
            s.sc = 0; s.mn++;
            if (s.mn == 60) begin
                s.mn = 0; s.hr++;
                if (s.hr == 24) begin
                    s.hr = 0; s.dy++;
                    if (s.dy > days_in(s.yr, s.mo)) begin
                        s.dy = 1; s.mo++;
                        if (s.mo == 13) begin
                            s.mo = 1; s.yr++;
                            if (s.yr > 99) s.yr = 0;
                        end
                    end
                end
            end
        end
        return s;
    endfunction

    // Calendar clean-up applied to a committed date
    function automatic model_t load_date(model_t s, logic [15:0] d);
        s.yr = d[15:9]; s.mo = d[8:5]; s.dy = d[4:0];
        if (s.mo < 1 || s.mo > 12) s.mo = 1;
        if (s.yr > 99) s.yr = 99;
        if (s.dy < 1) s.dy = 1;
        if (s.dy > days_in(s.yr, s.mo)) s.dy = days_in(s.yr, s.mo);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput(input string name);
        check({name, "_time"},  {14'd0, CUR_TIME},  {14'd0, mk_time(m.mer, m.hr, m.mn, m.sc)});
        check({name, "_date"},  {16'd0, CUR_DATE},  {16'd0, mk_date(m.yr, m.mo, m.dy)});
        check({name, "_alarm"}, {15'd0, CUR_ALARM}, {15'd0, mk_alarm(m.ahr, m.amn, m.asc)});
    endtask

    always @(negedge CLK) begin
        ack_exp_t e;
        int       hc;
        if (SETTING_OK === 1'b1) begin
            if (ack_q.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL unexpected_ack: got SETTING_OK=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = ack_q.pop_front();
                check("ack_time",  {14'd0, CUR_TIME},  {14'd0, e.t});
                check("ack_date",  {16'd0, CUR_DATE},  {16'd0, e.d});
                check("ack_alarm", {15'd0, CUR_ALARM}, {15'd0, e.a});
            end
        end
        if (ALARM_HIT === 1'b1) begin
            if (hit_q.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL unexpected_alarm_hit: got ALARM_HIT=1, expected 0 (cycle %0d)", cyc);
            end else begin
                hc = hit_q.pop_front();
                check("alarm_hit_cycle", cyc, hc);
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESETN = 1'b0; TICK = 1'b0; SETTING = 1'b0; MODE = 6'd0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        m = model_reset();
    endtask

    // One TICK cycle; the model counts unless MODE[0] stops counting
    task automatic applyStimulus(input bit stop, input string name);
        @(negedge CLK);
        TICK = 1'b1;
        MODE = {5'd0, stop};
        if (!stop) begin
            m = step(m);
            if (ALARM_ENABLE && m.hr == m.ahr && m.mn == m.amn && m.sc == m.asc)
                hit_q.push_back(cyc + 1);
        end
        @(negedge CLK);
        TICK = 1'b0;
        checkOutput(name);
    endtask

    task automatic commitSetting(input bit to_alarm, input logic [17:0] t, input logic [15:0] d,
                                 input logic [16:0] a, input bit tick_rise, input int hold);
        ack_exp_t    e;
        logic [17:0] old_t;
        int          lat;
        old_t = mk_time(m.mer, m.hr, m.mn, m.sc);
        if (!to_alarm) begin
            m.mer = t[17]; m.hr = t[16:12]; m.mn = t[11:6]; m.sc = t[5:0];
            m = load_date(m, d);
        end else begin
            m.ahr = a[16:12]; m.amn = a[11:6]; m.asc = a[5:0];
        end
        e.t = mk_time(m.mer, m.hr, m.mn, m.sc);
        e.d = mk_date(m.yr, m.mo, m.dy);
        e.a = mk_alarm(m.ahr, m.amn, m.asc);
        ack_q.push_back(e);

        @(negedge CLK);
        NEW_TIME = t; NEW_DATE = d; NEW_ALARM = a;
        MODE = {to_alarm, 4'b1001, ~tick_rise};
        SETTING = 1'b1;
        TICK = tick_rise;
        @(negedge CLK);
        TICK = 1'b0;
        check("commit_busy", {31'd0, BUSY}, 32'd1);
        check("commit_not_early", {14'd0, CUR_TIME}, {14'd0, old_t});
        lat = 1;
        while (SETTING_OK !== 1'b1 && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        check("ack_latency", lat, 2);
        TICK = 1'b1;
        MODE[0] = 1'b0;
        @(negedge CLK);
        TICK = 1'b0;
        MODE[0] = 1'b1;
        repeat (hold) @(negedge CLK);
        SETTING = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_after_drop", {31'd0, BUSY}, 32'd0);
        checkOutput("post_commit");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_t f;
        int     r, k;
        RESETN = 1'b0; TICK = 1'b0; SETTING = 1'b0; MODE = 6'd0; ALARM_ENABLE = 1'b0;
        NEW_TIME = '0; NEW_DATE = '0; NEW_ALARM = '0;

        do_reset();
        check("reset_time",  {14'd0, CUR_TIME},  32'd0);
        check("reset_date",  {16'd0, CUR_DATE},  32'h0021);
        check("reset_alarm", {15'd0, CUR_ALARM}, 32'd0);
        check("reset_busy",  {31'd0, BUSY},      32'd0);
        check("reset_ok",    {31'd0, SETTING_OK}, 32'd0);
        repeat (3) applyStimulus(1'b0, "count");
        check("three_ticks_time", {14'd0, CUR_TIME}, 32'd3);
        check("three_ticks_date", {16'd0, CUR_DATE}, 32'h0021);
        applyStimulus(1'b1, "stopped");
        check("stopped_time", {14'd0, CUR_TIME}, 32'd3);

        commitSetting(1'b0, mk_time(0, 23, 59, 59), mk_date(3, 2, 28), '0, 1'b0, 0);
        applyStimulus(1'b0, "roll_y3");
        check("roll_y3_date", {16'd0, CUR_DATE}, {16'd0, mk_date(3, 3, 1)});
        commitSetting(1'b0, mk_time(0, 23, 59, 59), mk_date(4, 2, 28), '0, 1'b0, 0);
        applyStimulus(1'b0, "roll_y4");
        check("roll_y4_date", {16'd0, CUR_DATE}, {16'd0, mk_date(4, 2, 29)});
        commitSetting(1'b0, mk_time(1, 23, 59, 59), mk_date(99, 12, 31), '0, 1'b0, 0);
        applyStimulus(1'b0, "roll_y99");
        check("roll_y99_time", {14'd0, CUR_TIME}, {14'd0, mk_time(1, 0, 0, 0)});
        check("roll_y99_date", {16'd0, CUR_DATE}, {16'd0, mk_date(0, 1, 1)});

        commitSetting(1'b0, mk_time(0, 12, 34, 56), mk_date(5, 2, 31), '0, 1'b0, 10);
        check("sanitised_date", {16'd0, CUR_DATE}, {16'd0, mk_date(5, 2, 28)});
        check("sanitised_time", {14'd0, CUR_TIME}, {14'd0, mk_time(0, 12, 34, 56)});
        commitSetting(1'b0, mk_time(1, 8, 0, 0), mk_date(10, 6, 15), '0, 1'b1, 2);
        check("tick_at_rise_time", {14'd0, CUR_TIME}, {14'd0, mk_time(1, 8, 0, 0)});

        do_reset();
        ALARM_ENABLE = 1'b1;
        commitSetting(1'b1, mk_time(0, 5, 5, 5), mk_date(7, 7, 7), mk_alarm(0, 0, 5), 1'b0, 0);
        repeat (8) applyStimulus(1'b0, "alarm_on");
        do_reset();
        ALARM_ENABLE = 1'b0;
        commitSetting(1'b1, mk_time(0, 5, 5, 5), mk_date(7, 7, 7), mk_alarm(0, 0, 5), 1'b0, 0);
        repeat (8) applyStimulus(1'b0, "alarm_off");

        do_reset();
        commitSetting(1'b0, mk_time(0, 10, 0, 0), mk_date(20, 5, 5), '0, 1'b0, 0);
        m.hr = 11;
        ack_q.push_back('{t: mk_time(0, 11, 0, 0), d: mk_date(20, 5, 5), a: 17'd0});
        @(negedge CLK);
        NEW_TIME = mk_time(0, 11, 0, 0); NEW_DATE = mk_date(20, 5, 5);
        MODE = 6'b010011; SETTING = 1'b1;
        repeat (2) @(negedge CLK);
        check("ack_before_reset", {31'd0, SETTING_OK}, 32'd1);
        RESETN = 1'b0; SETTING = 1'b0;
        @(negedge CLK);
        check("abort_ok",    {31'd0, SETTING_OK}, 32'd0);
        check("abort_busy",  {31'd0, BUSY},       32'd0);
        check("abort_hit",   {31'd0, ALARM_HIT},  32'd0);
        check("abort_time",  {14'd0, CUR_TIME},   32'd0);
        check("abort_date",  {16'd0, CUR_DATE},   32'h0021);
        check("abort_alarm", {15'd0, CUR_ALARM},  32'd0);
        RESETN = 1'b1;
        m = model_reset();

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                applyStimulus($urandom_range(0, 4) == 0, "rand_tick");
            end else if (r == 6) begin
                commitSetting(1'b0,
                    mk_time($urandom_range(0, 1), $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59)),
                    mk_date($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 31)),
                    17'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            end else if (r == 7) begin
                f = m;
                k = $urandom_range(1, 6);
                repeat (k) f = step(f);
                commitSetting(1'b1, 18'($urandom), 16'($urandom), mk_alarm(f.hr, f.mn, f.sc),
                              $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            end else if (r == 8) begin
                k = $urandom_range(0, 99);
                f.mo = $urandom_range(1, 12);
                commitSetting(1'b0,
                    mk_time($urandom_range(0, 1), 23, 59, $urandom_range(55, 59)),
                    mk_date(k, f.mo, days_in(k, f.mo)), '0, 1'b0, $urandom_range(0, 2));
            end else begin
                ALARM_ENABLE = $urandom_range(0, 3) != 0;
            end
        end
        repeat (3) @(negedge CLK);

        check("pending_acks", ack_q.size(), 0);
        check("pending_alarm_hits", hit_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
